// File: rtl/game_timer_pkg.sv
// Shared types, 7-segment patterns and BCD helper for the dance-game round timer.
package game_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSED,
        ST_DONE
    } timer_state_t;

    // Active-low segment patterns {g,f,e,d,c,b,a}, indexed by digit value.
    localparam logic [9:0][6:0] SEG7 = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Repeated subtraction keeps the conversion free of divide/modulo; valid for 0..99.
    function automatic logic [7:0] bin_to_bcd(input logic [6:0] value);
        logic [6:0] rem;
        logic [3:0] tens;
        rem  = value;
        tens = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Single BCD digit to active-low 7-segment pattern; non-decimal codes are blanked.
module seven_seg_decoder
    import game_timer_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG7[digit];
        end
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: BCD seconds counter with start/pause/load, low-time warning,
// blinking HEX5/HEX4 display and a time-up pulse for the game FSM.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned MAX_SECONDS     = 99,
    parameter int unsigned DEFAULT_SECONDS = 60,
    parameter int unsigned WARN_SECONDS    = 10,
    parameter bit          BLINK_EN        = 1'b1
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       load,
    input  logic [6:0] load_seconds,
    output logic [7:0] seconds_bcd,
    output logic       running,
    output logic       warning,
    output logic       tick,
    output logic       time_up,
    output logic       game_over,
    output logic [6:0] HEX5,
    output logic [6:0] HEX4
);

    localparam int unsigned    PW          = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]  PRESC_LAST  = PW'(CLK_HZ - 1);
    localparam logic [PW-1:0]  PRESC_HALF  = PW'(CLK_HZ / 2);
    localparam logic [6:0]     MAX_LOAD    = 7'(MAX_SECONDS);
    localparam logic [7:0]     DEFAULT_BCD = bin_to_bcd(7'(DEFAULT_SECONDS));
    localparam logic [7:0]     WARN_BCD    = bin_to_bcd(7'(WARN_SECONDS));

    timer_state_t  state, state_n;
    logic [3:0]    tens, ones, tens_n, ones_n;
    logic [3:0]    dec_tens, dec_ones;
    logic [PW-1:0] presc, presc_n;
    logic          tick_n, time_up_n, warn_n;
    logic [6:0]    load_val;
    logic [7:0]    load_bcd;
    logic [6:0]    seg_tens, seg_ones;
    logic          blank;

    seven_seg_decoder u_seg_tens (.digit(tens), .seg(seg_tens));
    seven_seg_decoder u_seg_ones (.digit(ones), .seg(seg_ones));

    assign seconds_bcd = {tens, ones};

    always_comb begin
        if (ones == 4'd0) begin
            dec_ones = 4'd9;
            dec_tens = tens - 4'd1;
        end else begin
            dec_ones = ones - 4'd1;
            dec_tens = tens;
        end
        load_val = (load_seconds > MAX_LOAD) ? MAX_LOAD : load_seconds;
        load_bcd = bin_to_bcd(load_val);
    end

    always_comb begin
        state_n   = state;
        tens_n    = tens;
        ones_n    = ones;
        presc_n   = presc;
        tick_n    = 1'b0;
        time_up_n = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load) begin
                    {tens_n, ones_n} = load_bcd;
                    presc_n          = '0;
                end else if (start) begin
                    presc_n = '0;
                    if ({tens, ones} == 8'h00) begin
                        state_n   = ST_DONE;
                        time_up_n = 1'b1;
                    end else begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // The prescaler advances in the cycle pause is seen, so a resume
                // continues exactly where the paused second left off.
                if (presc == PRESC_LAST) begin
                    presc_n = '0;
                    tick_n  = 1'b1;
                    tens_n  = dec_tens;
                    ones_n  = dec_ones;
                    if ({dec_tens, dec_ones} == 8'h00) begin
                        state_n   = ST_DONE;
                        time_up_n = 1'b1;
                    end else if (pause) begin
                        state_n = ST_PAUSED;
                    end
                end else begin
                    presc_n = presc + 1'b1;
                    if (pause) begin
                        state_n = ST_PAUSED;
                    end
                end
            end
            ST_PAUSED: begin
                if (!pause) begin
                    state_n = ST_RUN;
                end
            end
            ST_DONE: begin
                if (load) begin
                    {tens_n, ones_n} = load_bcd;
                    presc_n          = '0;
                    state_n          = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        warn_n = ((state_n == ST_RUN) || (state_n == ST_PAUSED)) &&
                 ({tens_n, ones_n} != 8'h00) && ({tens_n, ones_n} <= WARN_BCD);
    end

    assign blank = warning && BLINK_EN && (presc >= PRESC_HALF);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tens      <= DEFAULT_BCD[7:4];
            ones      <= DEFAULT_BCD[3:0];
            presc     <= '0;
            tick      <= 1'b0;
            time_up   <= 1'b0;
            game_over <= 1'b0;
            running   <= 1'b0;
            warning   <= 1'b0;
            HEX5      <= SEG7[DEFAULT_BCD[7:4]];
            HEX4      <= SEG7[DEFAULT_BCD[3:0]];
        end else begin
            state     <= state_n;
            tens      <= tens_n;
            ones      <= ones_n;
            presc     <= presc_n;
            tick      <= tick_n;
            time_up   <= time_up_n;
            game_over <= (state_n == ST_DONE);
            running   <= (state_n == ST_RUN);
            warning   <= warn_n;
            HEX5      <= blank ? SEG_BLANK : seg_tens;
            HEX4      <= blank ? SEG_BLANK : seg_ones;
        end
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer with CLK_HZ=10: pulse and snapshot queues
// filled by the stimulus, drained by a negedge monitor.
module tb_game_countdown_timer;

    localparam int unsigned CLK_HZ = 10;

    logic       CLOCK_50;
    logic       reset;
    logic       start;
    logic       pause;
    logic       load;
    logic [6:0] load_seconds;
    logic [7:0] seconds_bcd;
    logic       running;
    logic       warning;
    logic       tick;
    logic       time_up;
    logic       game_over;
    logic [6:0] HEX5;
    logic [6:0] HEX4;

    game_countdown_timer #(.CLK_HZ(CLK_HZ)) u_dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .start       (start),
        .pause       (pause),
        .load        (load),
        .load_seconds(load_seconds),
        .seconds_bcd (seconds_bcd),
        .running     (running),
        .warning     (warning),
        .tick        (tick),
        .time_up     (time_up),
        .game_over   (game_over),
        .HEX5        (HEX5),
        .HEX4        (HEX4)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [7:0] bcd;
        logic [6:0] hex5;
        logic [6:0] hex4;
        logic       running;
        logic       warning;
        logic       tick;
        logic       time_up;
        logic       game_over;
    } obs_t;

    typedef struct {
        obs_t  exp;
        bit    hex_chk;
        string name;
    } chk_t;

    chk_t pulse_q[$];
    chk_t snap_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    obs_t act;
    chk_t cur;

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // hv < 0 means both digits blanked, otherwise hv is the value shown on HEX5/HEX4.
    function automatic obs_t mk(input int v, input bit run, input bit warn, input bit tk,
                                input bit tu, input bit go, input int hv);
        obs_t o;
        o.bcd       = {4'(v / 10), 4'(v % 10)};
        o.hex5      = (hv < 0) ? 7'h7F : seg(hv / 10);
        o.hex4      = (hv < 0) ? 7'h7F : seg(hv % 10);
        o.running   = run;
        o.warning   = warn;
        o.tick      = tk;
        o.time_up   = tu;
        o.game_over = go;
        return o;
    endfunction

    task automatic push_snap(input string name, input obs_t e, input bit hc);
        snap_q.push_back('{e, hc, name});
    endtask

    task automatic push_pulse(input string name, input obs_t e);
        pulse_q.push_back('{e, 1'b0, name});
    endtask

    task automatic check(input chk_t c, input obs_t a_in);
        obs_t a, e;
        a = a_in;
        e = c.exp;
        if (!c.hex_chk) begin
            a.hex5 = '0; a.hex4 = '0;
            e.hex5 = '0; e.hex4 = '0;
        end
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got bcd=%h hex=%b/%b run=%b warn=%b tick=%b tu=%b go=%b, exp bcd=%h hex=%b/%b run=%b warn=%b tick=%b tu=%b go=%b",
                     c.name, a.bcd, a.hex5, a.hex4, a.running, a.warning, a.tick, a.time_up, a.game_over,
                     e.bcd, e.hex5, e.hex4, e.running, e.warning, e.tick, e.time_up, e.game_over);
        end
    endtask

    always @(negedge CLOCK_50) begin
        act = {seconds_bcd, HEX5, HEX4, running, warning, tick, time_up, game_over};
        if (tick || time_up) begin
            if (pulse_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pulse: got bcd=%h tick=%b tu=%b, exp no pulse", seconds_bcd, tick, time_up);
            end else begin
                cur = pulse_q.pop_front();
                check(cur, act);
            end
        end
        while (snap_q.size() > 0) begin
            cur = snap_q.pop_front();
            check(cur, act);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        pause        = 1'b0;
        load         = 1'b0;
        load_seconds = '0;
        step(2);
        push_snap("reset", mk(60, 0, 0, 0, 0, 0, 60), 1);
        step(1);
        reset = 1'b0;

        // Full 60 s round with no pause; blink window checked at 10 s.
        for (int k = 1; k <= 60; k++) begin
            push_pulse($sformatf("tick_to_%0d", 60 - k),
                       mk(60 - k, k < 60, (60 - k) > 0 && (60 - k) <= 10, 1, k == 60, k == 60, 0));
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        push_snap("run_start", mk(60, 1, 0, 0, 0, 0, 60), 1);
        step(9);
        push_snap("pre_first_tick", mk(60, 1, 0, 0, 0, 0, 60), 1);
        step(1);
        push_snap("first_tick", mk(59, 1, 0, 1, 0, 0, 60), 1);
        step(490);
        for (int j = 1; j <= 10; j++) begin
            step(1);
            push_snap($sformatf("blink_%0d", j),
                      mk((j < 10) ? 10 : 9, 1, 1, j == 10, 0, 0, (j >= 6) ? -1 : 10), 1);
        end
        step(89);
        push_snap("last_second", mk(1, 1, 1, 0, 0, 0, -1), 1);
        step(1);
        push_snap("time_up_edge", mk(0, 0, 0, 1, 1, 1, 0), 0);
        step(1);
        push_snap("time_up_drop", mk(0, 0, 0, 0, 0, 1, 0), 1);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(3);
        push_snap("done_ignores_start", mk(0, 0, 0, 0, 0, 1, 0), 1);

        // Load clamping and start from zero.
        load_seconds = 7'd120;
        load = 1'b1;
        step(1);
        load = 1'b0;
        push_snap("load_clamp_99", mk(99, 0, 0, 0, 0, 0, 0), 0);
        load_seconds = 7'd0;
        load = 1'b1;
        step(1);
        load = 1'b0;
        push_snap("load_zero", mk(0, 0, 0, 0, 0, 0, 0), 0);
        push_pulse("zero_start_pulse", mk(0, 0, 0, 0, 1, 1, 0));
        start = 1'b1;
        step(1);
        start = 1'b0;
        push_snap("zero_start_done", mk(0, 0, 0, 0, 1, 1, 0), 0);
        step(1);
        push_snap("zero_start_drop", mk(0, 0, 0, 0, 0, 1, 0), 0);

        // Pause retention, tick+pause, then reset mid-run.
        load_seconds = 7'd46;
        load = 1'b1;
        step(1);
        load = 1'b0;
        push_snap("load_46", mk(46, 0, 0, 0, 0, 0, 0), 0);
        push_pulse("tick_to_45", mk(45, 1, 0, 1, 0, 0, 0));
        push_pulse("tick_to_44", mk(44, 1, 0, 1, 0, 0, 0));
        push_pulse("tick_pause_43", mk(43, 0, 0, 1, 0, 0, 0));
        for (int v = 42; v >= 33; v--) begin
            push_pulse($sformatf("tick_to_%0d", v), mk(v, 1, 0, 1, 0, 0, 0));
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(10);
        step(3);
        pause = 1'b1;
        step(37);
        push_snap("paused_hold", mk(45, 0, 0, 0, 0, 0, 0), 0);
        pause = 1'b0;
        step(6);
        push_snap("resume_pre_tick", mk(45, 1, 0, 0, 0, 0, 0), 0);
        step(1);
        push_snap("resume_tick_7", mk(44, 1, 0, 1, 0, 0, 0), 0);
        step(9);
        pause = 1'b1;
        step(1);
        push_snap("tick_with_pause", mk(43, 0, 0, 1, 0, 0, 0), 0);
        step(3);
        push_snap("tick_pause_hold", mk(43, 0, 0, 0, 0, 0, 0), 0);
        pause = 1'b0;
        step(1);
        step(101);
        push_snap("run_at_33", mk(33, 1, 0, 0, 0, 0, 0), 0);
        step(1);
        reset = 1'b1;
        #1;
        push_snap("reset_mid_run", mk(60, 0, 0, 0, 0, 0, 60), 1);
        step(1);
        reset = 1'b0;
        load_seconds = 7'd20;
        load  = 1'b1;
        start = 1'b1;
        step(1);
        load  = 1'b0;
        start = 1'b0;
        push_snap("load_beats_start", mk(20, 0, 0, 0, 0, 0, 0), 0);
        step(12);
        push_snap("still_idle_20", mk(20, 0, 0, 0, 0, 0, 0), 0);
        step(1);

        n_cmp++;
        if (pulse_q.size() != 0) begin
            n_bad++;
            $display("FAIL pulse_queue_drain: got %0d pending pulses, exp 0", pulse_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
